alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Upstream command stage for the tiny ALU. It buffers operation requests in a small FIFO and issues them one at a time over the ALU start/done handshake. It holds the operands stable for the whole operation, captures result/err/gp when done is seen, and presents each completion on a valid/ready response port. Illegal opcodes and hung operations are turned into error responses, so the ALU never sees an opcode it cannot decode.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of 2, ≥2
- TIMEOUT, 1024: max cycles in WAIT before abort (used only with timeout feature)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_a, cmd_b  in  32 each  operands
- cmd_sv  in  1  signed/variant flag
- cmd_prefix  in  1  op prefix bit
- cmd_op  in  8  opcode, 0..10 legal
- alu_start  out  1  ALU start strobe
- alu_a, alu_b  out  32 each  operands to ALU
- alu_sv, alu_op_prefix  out  1 each  flags to ALU
- alu_op  out  8  opcode to ALU
- alu_done  in  1  ALU completion
- alu_result  in  64  ALU result
- alu_err  in  8  ALU error code
- alu_gp  in  1  ALU general-purpose flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_result  out  64  captured result
- rsp_err  out  8  captured or generated error
- rsp_gp  out  1  captured gp
- rsp_op  out  8  opcode of the completed command
- fifo_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FIFO: a push occurs on a clk edge with cmd_valid && cmd_ready. The entry stores {a, b, sv, prefix, op}. cmd_ready = (fifo_count != DEPTH), driven from registered state. Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, FIFO non-empty, head op ≤ 10 → ISSUE.
- IDLE, FIFO non-empty, head op > 10 → RESP. The entry is popped and the response is rsp_err=8'hFF, rsp_result=0, rsp_gp=0. The ALU is not touched.
- ISSUE: alu_start=1 for exactly this one cycle. alu_* operands are loaded from the FIFO head on entry. → WAIT.
- WAIT: alu_start=0 and alu_* held stable. When alu_done=1 is sampled, the stage captures alu_result/err/gp and head op into rsp_*, pops the head, and goes → RESP.
- RESP: rsp_valid=1 and rsp_* stable until a cycle with rsp_ready=1, then → IDLE. No new issue happens while a response is pending, so at most one ALU operation is in flight.
- alu_done is ignored in IDLE, ISSUE and RESP.

## Timing
- Reset values: alu_start=0, alu_a/b=0, alu_sv=0, alu_op_prefix=0, alu_op=0, rsp_valid=0, rsp_result=0, rsp_err=0, rsp_gp=0, rsp_op=0, fifo_count=0, cmd_ready=1, state IDLE.
- Reset asserted mid-operation: state, FIFO contents and outputs return to reset values immediately. The in-flight ALU result is discarded.
- Push to empty FIFO at edge N: ISSUE at N+1, alu_start high during cycle N+1..N+2, WAIT from N+2.
- alu_done sampled high at edge M: rsp_valid high from M. Earliest return to IDLE is M+1 if rsp_ready is already high.
- Minimum spacing between consecutive alu_start pulses: 4 cycles.

## Configuration
- ALU_ISSUER_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle. Reaching TIMEOUT with no alu_done pops the head and goes → RESP with rsp_err=8'hFE, rsp_result=0, rsp_gp=0. alu_done on the same edge as the timeout wins over the timeout.
- Not defined: no counter; WAIT lasts until alu_done, possibly forever. The TIMEOUT parameter is unused.

## Test plan
- Single add: push a=5, b=7, op=1; ALU model returns 64'd12, err=0 after 3 cycles → one alu_start pulse, alu_a=5, alu_b=7 stable through WAIT; rsp_result=12, rsp_err=0, rsp_op=1.
- Back-pressure: push 5 commands with DEPTH=4 and the ALU stalled → cmd_ready=0 after the 4th, fifo_count=4. The 5th is accepted only after the first pop. Responses come out in push order.
- Illegal opcode: push op=8'd11 then op=2 → first response rsp_err=8'hFF with no alu_start; the second issues normally.
- Response stall: hold rsp_ready=0 for 10 cycles with 2 queued → rsp_* unchanged, no second alu_start until the handshake completes.
- Timeout (macro defined, TIMEOUT=16): ALU never asserts done → rsp_err=8'hFE exactly 16 cycles after WAIT entry. Without the macro, still in WAIT after 100 cycles.
- Async reset during WAIT with 3 queued → alu_start=0, fifo_count=0, rsp_valid=0 before the next clk edge; no response is produced afterwards.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus single-in-flight issuer for the tiny ALU start/done handshake.
// Optional WAIT watchdog enabled by defining ALU_ISSUER_TIMEOUT_EN.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic                     cmd_sv,
  input  logic                     cmd_prefix,
  input  logic [7:0]               cmd_op,
  output logic                     alu_start,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic                     alu_sv,
  output logic                     alu_op_prefix,
  output logic [7:0]               alu_op,
  input  logic                     alu_done,
  input  logic [63:0]              alu_result,
  input  logic [7:0]               alu_err,
  input  logic                     alu_gp,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [63:0]              rsp_result,
  output logic [7:0]               rsp_err,
  output logic                     rsp_gp,
  output logic [7:0]               rsp_op,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sv;
    logic        prefix;
    logic [7:0]  op;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  state_e          state_q;

  entry_t          head;
  entry_t          cmd_entry;
  logic            empty, head_legal, push, pop, timeout_hit;

  assign head       = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign head_legal = (head.op <= 8'd10);
  assign cmd_ready  = (count_q != CW'(DEPTH));
  assign fifo_count = count_q;
  assign push       = cmd_valid && cmd_ready;
  assign cmd_entry  = '{a: cmd_a, b: cmd_b, sv: cmd_sv, prefix: cmd_prefix, op: cmd_op};

  // Head leaves the FIFO only once its response is decided.
  assign pop = ((state_q == StIdle) && !empty && !head_legal) ||
               ((state_q == StWait) && (alu_done || timeout_hit));

`ifdef ALU_ISSUER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q;

  assign timeout_hit = (wait_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q != StWait) begin
      wait_cnt_q <= '0;
    end else if (!timeout_hit) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  // TIMEOUT has no effect in this build.
  assign timeout_hit = (TIMEOUT == 0) & 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cmd_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      alu_start     <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sv        <= 1'b0;
      alu_op_prefix <= 1'b0;
      alu_op        <= '0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_err       <= '0;
      rsp_gp        <= 1'b0;
      rsp_op        <= '0;
    end else begin
      alu_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            if (head_legal) begin
              state_q       <= StIssue;
              alu_start     <= 1'b1;
              alu_a         <= head.a;
              alu_b         <= head.b;
              alu_sv        <= head.sv;
              alu_op_prefix <= head.prefix;
              alu_op        <= head.op;
            end else begin
              state_q    <= StResp;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_err    <= 8'hFF;
              rsp_gp     <= 1'b0;
              rsp_op     <= head.op;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (alu_done) begin
            state_q    <= StResp;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_err    <= alu_err;
            rsp_gp     <= alu_gp;
            rsp_op     <= head.op;
          end else if (timeout_hit) begin
            state_q    <= StResp;
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_err    <= 8'hFE;
            rsp_gp     <= 1'b0;
            rsp_op     <= head.op;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized self-checking bench for alu_cmd_issuer with a behavioural ALU and
// an in-order response reference; honours ALU_ISSUER_TIMEOUT_EN when defined.
module tb_alu_cmd_issuer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sv;
    logic        pre;
    logic [7:0]  op;
  } cmd_t;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  err;
    logic        gp;
    logic [7:0]  op;
  } rsp_t;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        cmd_sv, cmd_prefix;
  logic [7:0]  cmd_op;
  logic        alu_start;
  logic [31:0] alu_a, alu_b;
  logic        alu_sv, alu_op_prefix;
  logic [7:0]  alu_op;
  logic        alu_done;
  logic [63:0] alu_result;
  logic [7:0]  alu_err;
  logic        alu_gp;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic [7:0]  rsp_err;
  logic        rsp_gp;
  logic [7:0]  rsp_op;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic alu_hold = 1'b0;
  int   alu_lat  = 3;
  bit   lat_rand = 1'b0;
  bit   alu_busy = 1'b0;
  int   alu_wait = 0;
  cmd_t alu_cur;
  bit   rdy_force = 1'b1;
  logic rdy_val   = 1'b1;

  cmd_t start_q[$];
  int   start_cyc[$];
  rsp_t obs_q[$];
  int   obs_cyc[$];
  rsp_t exp_q[$];
  cmd_t issue_q[$];
  int   unstable = 0;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sv(cmd_sv), .cmd_prefix(cmd_prefix), .cmd_op(cmd_op),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_sv(alu_sv),
    .alu_op_prefix(alu_op_prefix), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err), .alu_gp(alu_gp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_gp(rsp_gp), .rsp_op(rsp_op), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic cmd_t mk_cmd(logic [31:0] a, logic [31:0] b, logic sv, logic pre,
                                  logic [7:0] op);
    cmd_t c;
    c.a = a; c.b = b; c.sv = sv; c.pre = pre; c.op = op;
    return c;
  endfunction

  function automatic rsp_t mk_rsp(logic [63:0] res, logic [7:0] err, logic gp, logic [7:0] op);
    rsp_t r;
    r.res = res; r.err = err; r.gp = gp; r.op = op;
    return r;
  endfunction

  function automatic cmd_t rand_cmd(int unsigned max_op);
    return mk_cmd($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, max_op)));
  endfunction

  // Behaviour of the toy ALU: op 1 adds, others produce a mixed pattern.
  function automatic rsp_t alu_fn(cmd_t c);
    logic [63:0] res;
    res = (c.op == 8'd1) ? (64'(c.a) + 64'(c.b)) : {c.a ^ c.b, c.b - {24'b0, c.op}};
    return mk_rsp(res, (c.op == 8'd10) ? 8'h3C : 8'h00, c.sv ^ c.pre, c.op);
  endfunction

  function automatic rsp_t exp_of(cmd_t c);
    if (c.op > 8'd10) return mk_rsp(64'd0, 8'hFF, 1'b0, c.op);
    return alu_fn(c);
  endfunction

  // ALU model: latency counted from the start strobe, frozen while alu_hold is set.
  initial begin
    alu_done = 1'b0; alu_result = '0; alu_err = '0; alu_gp = 1'b0;
    forever begin
      @(posedge clk); #1;
      alu_done   = 1'b0;
      alu_result = {$urandom, $urandom};
      alu_err    = 8'($urandom);
      alu_gp     = 1'($urandom_range(0, 1));
      if (reset) begin
        alu_busy = 1'b0;
      end else begin
        if (alu_busy && !alu_hold) begin
          if (alu_wait == 0) begin
            rsp_t r;
            r = alu_fn(alu_cur);
            alu_result = r.res; alu_err = r.err; alu_gp = r.gp; alu_done = 1'b1;
            alu_busy = 1'b0;
          end else begin
            alu_wait--;
          end
        end
        if (alu_start) begin
          alu_cur  = mk_cmd(alu_a, alu_b, alu_sv, alu_op_prefix, alu_op);
          alu_busy = 1'b1;
          alu_wait = (lat_rand ? int'($urandom_range(1, 5)) : alu_lat) - 1;
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rsp_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
    end
  end

  // Observer: logs issues and handshakes, counts operand changes outside a start.
  initial begin
    cmd_t prev, now;
    bit   prev_ok;
    prev_ok = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ok = 1'b0;
      end else begin
        now = mk_cmd(alu_a, alu_b, alu_sv, alu_op_prefix, alu_op);
        if (alu_start) begin
          start_q.push_back(now);
          start_cyc.push_back(cyc);
        end else if (prev_ok && now != prev) begin
          unstable++;
        end
        prev = now; prev_ok = 1'b1;
        if (rsp_valid && rsp_ready) begin
          obs_q.push_back(mk_rsp(rsp_result, rsp_err, rsp_gp, rsp_op));
          obs_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_sb();
    start_q.delete(); start_cyc.delete(); obs_q.delete(); obs_cyc.delete();
    exp_q.delete(); issue_q.delete(); unstable = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    alu_hold = 1'b0;
    clear_sb();
  endtask

  task automatic push_cmd(input cmd_t c, output int acc_cyc);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_a = c.a; cmd_b = c.b; cmd_sv = c.sv; cmd_prefix = c.pre; cmd_op = c.op;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    checks++;
    if (acc) begin
      exp_q.push_back(exp_of(c));
      if (c.op <= 8'd10) issue_q.push_back(c);
    end else begin
      errors++;
      $display("FAIL push_accept: command op=%0d never accepted, required acceptance", c.op);
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (alu_start !== 1'b0) begin errors++;
      $display("FAIL reset_start: got %b want 0", alu_start); end
    checks++; if ({alu_a, alu_b} !== 64'd0) begin errors++;
      $display("FAIL reset_alu_ab: got %h want 0", {alu_a, alu_b}); end
    checks++; if ({alu_sv, alu_op_prefix, alu_op} !== 10'd0) begin errors++;
      $display("FAIL reset_alu_flags: got %h want 0", {alu_sv, alu_op_prefix, alu_op}); end
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_result, rsp_err, rsp_gp, rsp_op} !== 81'd0) begin errors++;
      $display("FAIL reset_rsp: got %h want 0", {rsp_result, rsp_err, rsp_gp, rsp_op}); end
    checks++; if (fifo_count !== '0) begin errors++;
      $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_sb();
  endtask

  task automatic test_single_add();
    int pc;
    rdy_force = 1'b1; rdy_val = 1'b1; lat_rand = 1'b0; alu_lat = 3; alu_hold = 1'b0;
    clear_sb();
    push_cmd(mk_cmd(32'd5, 32'd7, 1'b0, 1'b0, 8'd1), pc);
    wait_obs(1, 50);
    checks++; if (obs_q.size() != 1) begin errors++;
      $display("FAIL add_rsp_count: got %0d want 1", obs_q.size()); end
    checks++; if (start_q.size() != 1) begin errors++;
      $display("FAIL add_start_count: got %0d want 1", start_q.size()); end
    if (start_q.size() > 0) begin
      checks++; if (start_cyc[0] != pc + 1) begin errors++;
        $display("FAIL add_start_cycle: got %0d want %0d", start_cyc[0], pc + 1); end
      checks++; if (start_q[0] !== mk_cmd(32'd5, 32'd7, 1'b0, 1'b0, 8'd1)) begin errors++;
        $display("FAIL add_operands: got %h want a=5 b=7 op=1", start_q[0]); end
    end
    checks++; if (unstable != 0) begin errors++;
      $display("FAIL add_stable: got %0d changes want 0", unstable); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== mk_rsp(64'd12, 8'd0, 1'b0, 8'd1)) begin errors++;
        $display("FAIL add_rsp: got %h want result=12 err=0 op=1", obs_q[0]); end
      checks++; if (obs_cyc[0] != pc + 5) begin errors++;
        $display("FAIL add_rsp_cycle: got %0d want %0d", obs_cyc[0], pc + 5); end
    end
  endtask

  task automatic test_back_pressure();
    int pc, p5;
    cmd_t c5;
    rdy_force = 1'b1; rdy_val = 1'b1; lat_rand = 1'b0; alu_lat = 1; alu_hold = 1'b1;
    clear_sb();
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd(10), pc);
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++;
      $display("FAIL bp_count_full: got %0d want 4", fifo_count); end
    checks++; if (cmd_ready !== 1'b0) begin errors++;
      $display("FAIL bp_ready_full: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    c5 = rand_cmd(10);
    fork
      push_cmd(c5, p5);
      begin
        repeat (5) @(posedge clk);
        #1;
        checks++; if (exp_q.size() != 4) begin errors++;
          $display("FAIL bp_fifth_held: accepted %0d want 4", exp_q.size()); end
        alu_hold = 1'b0;
      end
    join
    wait_obs(5, 200);
    checks++; if (obs_q.size() != 5) begin errors++;
      $display("FAIL bp_rsp_count: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL bp_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < start_q.size() && i < issue_q.size(); i++) begin
      checks++; if (start_q[i] !== issue_q[i]) begin errors++;
        $display("FAIL bp_issue[%0d]: got %h want %h", i, start_q[i], issue_q[i]); end
    end
    if (obs_cyc.size() > 0) begin
      checks++; if (p5 <= obs_cyc[0]) begin errors++;
        $display("FAIL bp_fifth_after_pop: accepted at %0d want after %0d", p5, obs_cyc[0]); end
    end
  endtask

  task automatic test_illegal();
    int pc;
    cmd_t c1, c2;
    rdy_force = 1'b1; rdy_val = 1'b1; lat_rand = 1'b0; alu_lat = 2; alu_hold = 1'b0;
    clear_sb();
    c1 = rand_cmd(10); c1.op = 8'd11;
    c2 = rand_cmd(10); c2.op = 8'd2;
    push_cmd(c1, pc);
    push_cmd(c2, pc);
    wait_obs(2, 60);
    checks++; if (obs_q.size() != 2) begin errors++;
      $display("FAIL ill_rsp_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0] !== mk_rsp(64'd0, 8'hFF, 1'b0, 8'd11)) begin errors++;
        $display("FAIL ill_rsp: got %h want err=FF result=0 op=11", obs_q[0]); end
      checks++; if (obs_q[1] !== exp_q[1]) begin errors++;
        $display("FAIL ill_next_rsp: got %h want %h", obs_q[1], exp_q[1]); end
    end
    checks++; if (start_q.size() != 1) begin errors++;
      $display("FAIL ill_start_count: got %0d want 1", start_q.size()); end
    if (start_q.size() > 0) begin
      checks++; if (start_q[0] !== c2) begin errors++;
        $display("FAIL ill_issue: got %h want %h", start_q[0], c2); end
    end
  endtask

  task automatic test_rsp_stall();
    int pc, bad;
    rsp_t snap;
    rdy_force = 1'b1; rdy_val = 1'b0; lat_rand = 1'b0; alu_lat = 2; alu_hold = 1'b0;
    clear_sb();
    push_cmd(rand_cmd(10), pc);
    push_cmd(rand_cmd(10), pc);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    @(negedge clk);
    snap = mk_rsp(rsp_result, rsp_err, rsp_gp, rsp_op);
    checks++; if (rsp_valid !== 1'b1 || snap !== exp_q[0]) begin errors++;
      $display("FAIL stall_first: valid=%b rsp=%h want valid=1 %h", rsp_valid, snap, exp_q[0]); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || mk_rsp(rsp_result, rsp_err, rsp_gp, rsp_op) !== snap) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL stall_hold: %0d cycles changed want 0", bad); end
    checks++; if (start_q.size() != 1) begin errors++;
      $display("FAIL stall_no_issue: got %0d starts want 1", start_q.size()); end
    @(posedge clk); #1;
    rdy_val = 1'b1;
    wait_obs(2, 60);
    checks++; if (obs_q.size() != 2) begin errors++;
      $display("FAIL stall_rsp_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL stall_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (start_q.size() == 2 && obs_cyc.size() > 0) begin
      checks++; if (start_cyc[1] <= obs_cyc[0]) begin errors++;
        $display("FAIL stall_issue_order: start at %0d want after %0d", start_cyc[1], obs_cyc[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pc;
    rdy_force = 1'b1; rdy_val = 1'b1; lat_rand = 1'b0; alu_lat = 1; alu_hold = 1'b0;
    clear_sb();
    for (int i = 0; i < 3; i++) push_cmd(rand_cmd(10), pc);
    wait_obs(3, 60);
    checks++; if (start_q.size() != 3) begin errors++;
      $display("FAIL b2b_start_count: got %0d want 3", start_q.size()); end
    for (int i = 1; i < start_cyc.size(); i++) begin
      checks++; if (start_cyc[i] - start_cyc[i-1] != 4) begin errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, start_cyc[i] - start_cyc[i-1]); end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL b2b_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int pc;
    cmd_t c;
    rdy_force = 1'b1; rdy_val = 1'b1; lat_rand = 1'b0; alu_lat = 1; alu_hold = 1'b1;
    clear_sb();
    c = rand_cmd(10);
    push_cmd(c, pc);
`ifdef ALU_ISSUER_TIMEOUT_EN
    wait_obs(1, 80);
    checks++; if (obs_q.size() != 1) begin errors++;
      $display("FAIL to_rsp_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== mk_rsp(64'd0, 8'hFE, 1'b0, c.op)) begin errors++;
        $display("FAIL to_rsp: got %h want err=FE result=0 op=%0d", obs_q[0], c.op); end
      // WAIT is entered one cycle after the start strobe.
      checks++; if (obs_cyc[0] != pc + 2 + int'(TIMEOUT)) begin errors++;
        $display("FAIL to_cycle: got %0d want %0d", obs_cyc[0], pc + 2 + int'(TIMEOUT)); end
    end
`else
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || obs_q.size() != 0) begin errors++;
      $display("FAIL to_still_wait: rsp_valid=%b rsps=%0d want 0 0", rsp_valid, obs_q.size()); end
    checks++; if (fifo_count !== 3'd1) begin errors++;
      $display("FAIL to_count: got %0d want 1", fifo_count); end
`endif
    checks++; if (start_q.size() != 1) begin errors++;
      $display("FAIL to_start_count: got %0d want 1", start_q.size()); end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_async_reset();
    int pc;
    cmd_t c;
    rdy_force = 1'b1; rdy_val = 1'b1; lat_rand = 1'b0; alu_lat = 1; alu_hold = 1'b1;
    clear_sb();
    for (int i = 0; i < 3; i++) begin
      c = rand_cmd(10); c.a = c.a | 32'd1;
      push_cmd(c, pc);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (alu_start !== 1'b0 || alu_a !== 32'd0 || alu_op !== 8'd0) begin errors++;
      $display("FAIL ar_alu: start=%b a=%h op=%h want 0 0 0", alu_start, alu_a, alu_op); end
    checks++; if (fifo_count !== '0 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL ar_fifo: count=%0d ready=%b want 0 1", fifo_count, cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL ar_rsp_valid: got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    alu_hold = 1'b0;
    clear_sb();
    repeat (30) @(posedge clk);
    #1;
    checks++; if (obs_q.size() != 0 || start_q.size() != 0) begin errors++;
      $display("FAIL ar_quiet: rsps=%0d starts=%0d want 0 0", obs_q.size(), start_q.size()); end
  endtask

  task automatic test_random();
    int pc, minsp;
    rdy_force = 1'b0; lat_rand = 1'b1; alu_hold = 1'b0;
    clear_sb();
    for (int i = 0; i < 20; i++) begin
      push_cmd(rand_cmd(12), pc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_obs(20, 2000);
    checks++; if (obs_q.size() != 20) begin errors++;
      $display("FAIL rnd_rsp_count: got %0d want 20", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL rnd_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (start_q.size() != issue_q.size()) begin errors++;
      $display("FAIL rnd_issue_count: got %0d want %0d", start_q.size(), issue_q.size()); end
    for (int i = 0; i < start_q.size() && i < issue_q.size(); i++) begin
      checks++; if (start_q[i] !== issue_q[i]) begin errors++;
        $display("FAIL rnd_issue[%0d]: got %h want %h", i, start_q[i], issue_q[i]); end
    end
    minsp = 1000;
    for (int i = 1; i < start_cyc.size(); i++)
      if (start_cyc[i] - start_cyc[i-1] < minsp) minsp = start_cyc[i] - start_cyc[i-1];
    checks++; if (minsp < 4) begin errors++;
      $display("FAIL rnd_spacing: got %0d want >= 4", minsp); end
    checks++; if (unstable != 0) begin errors++;
      $display("FAIL rnd_stable: got %0d changes want 0", unstable); end
    rdy_force = 1'b1; rdy_val = 1'b1; lat_rand = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sv = 1'b0; cmd_prefix = 1'b0; cmd_op = '0;
    test_reset();
    test_single_add();
    test_back_pressure();
    test_illegal();
    test_rsp_stall();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
